// File: rtl/cam_pkg.sv
// Shared definitions for the camera stream generator and its capture-side peers.
// Contents: default frame timing constants, pattern mode and FSM state encodings,
// the latched per-frame configuration record and the RGB444 byte-packing helper.
package cam_pkg;

    localparam int CAM_H_ACTIVE = 160;
    localparam int CAM_V_ACTIVE = 120;
    localparam int CAM_H_BLANK  = 16;
    localparam int CAM_V_SYNC   = 3;
    localparam int CAM_V_BACK   = 4;
    localparam int CAM_V_FRONT  = 2;
    localparam int CAM_PCLK_DIV = 2;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_BOX   = 2'd2,
        MODE_TRI   = 2'd3
    } cam_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5,
        ST_CLOSE  = 3'd6
    } cam_state_e;

    // Per-frame configuration, captured when a frame enters VSYNC.
    typedef struct packed {
        cam_mode_e   mode;
        logic [11:0] fg;
        logic [11:0] bg;
        logic [11:0] box_w;
        logic [11:0] box_h;
    } cam_cfg_t;

    // Even byte carries {0, R}; odd byte carries {G, B}.
    function automatic logic [7:0] rgb444_byte(input logic [11:0] color, input logic odd);
        return odd ? color[7:0] : {4'b0000, color[11:8]};
    endfunction

endpackage

// File: rtl/cam_stream_gen_if.sv
// DVP-style parallel camera bus: pixel clock, frame sync, line valid, data byte.
// master: the sensor side (drives everything); slave: the capture side.
interface cam_stream_gen_if;
    logic       CAM_pclk;
    logic       CAM_vsync;
    logic       CAM_href;
    logic [7:0] CAM_px_data;

    modport master (output CAM_pclk, output CAM_vsync, output CAM_href, output CAM_px_data);
    modport slave  (input  CAM_pclk, input  CAM_vsync, input  CAM_href, input  CAM_px_data);
endinterface

// File: rtl/cam_pattern_rgb444.sv
// Combinational test-pattern map: (x, y, latched config) -> 12-bit RGB444 colour.
// Ports: x, y   pixel coordinates (zero-extended to 12 bits)
//        cfg    latched mode, colours and box size
//        color  fg or bg colour for this pixel
module cam_pattern_rgb444
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = CAM_H_ACTIVE,
    parameter int V_ACTIVE = CAM_V_ACTIVE
) (
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  cam_cfg_t    cfg,
    output logic [11:0] color
);

    localparam logic signed [12:0] CX = 13'(H_ACTIVE / 2);
    localparam logic signed [12:0] CY = 13'(V_ACTIVE / 2);

    logic signed [12:0] dx;
    logic signed [12:0] dy;
    logic signed [12:0] adx;
    logic signed [12:0] half_w;
    logic signed [12:0] half_h;
    logic               use_fg;

    always_comb begin
        use_fg = 1'b0;
        dx     = $signed({1'b0, x}) - CX;
        dy     = $signed({1'b0, y}) - CY;
        adx    = (dx < 0) ? -dx : dx;
        half_w = $signed({1'b0, cfg.box_w}) >>> 1;
        half_h = $signed({1'b0, cfg.box_h}) >>> 1;
        case (cfg.mode)
            MODE_SOLID: use_fg = 1'b1;
            MODE_BARS:  use_fg = x[4];
            // Half-open window [c - w/2, c + w/2) so an even box is exactly w wide.
            MODE_BOX:   use_fg = (dx >= -half_w) && (dx < half_w) &&
                                 (dy >= -half_h) && (dy < half_h);
            // Width 2y+1 centred on the middle column, saturating at the line width.
            MODE_TRI:   use_fg = (adx <= $signed({1'b0, y}));
            default:    use_fg = 1'b0;
        endcase
        color = use_fg ? cfg.fg : cfg.bg;
    end

endmodule

// File: rtl/cam_stream_gen.sv
// Camera-sensor emulator: emits RGB444 frames (two bytes per pixel) on a DVP bus.
// Ports: clk, CAM_reset_n (async, active low)
//        start (one-cycle frame request), cont (back-to-back frames)
//        mode, fg_color, bg_color, box_w, box_h (latched at start of VSYNC)
//        cam (bus master: pclk, vsync, href, data)
//        busy (start accepted .. end of closing vsync), frame_done (end of VFRONT)
module cam_stream_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = CAM_H_ACTIVE,
    parameter int V_ACTIVE = CAM_V_ACTIVE,
    parameter int H_BLANK  = CAM_H_BLANK,
    parameter int V_SYNC   = CAM_V_SYNC,
    parameter int V_BACK   = CAM_V_BACK,
    parameter int V_FRONT  = CAM_V_FRONT,
    parameter int PCLK_DIV = CAM_PCLK_DIV
) (
    input  logic                clk,
    input  logic                CAM_reset_n,
    input  logic                start,
    input  logic                cont,
    input  logic [1:0]          mode,
    input  logic [11:0]         fg_color,
    input  logic [11:0]         bg_color,
    input  logic [11:0]         box_w,
    input  logic [11:0]         box_h,
    cam_stream_gen_if.master    cam,
    output logic                busy,
    output logic                frame_done
);

    localparam int LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
    localparam int BW = $clog2(LINE_BYTES);
    localparam int LW = $clog2(V_ACTIVE + V_SYNC + V_BACK + V_FRONT);
    localparam int DW = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

    localparam logic [BW-1:0] BYTE_LAST = BW'(LINE_BYTES - 1);
    localparam logic [BW-1:0] ACT_LAST  = BW'(2 * H_ACTIVE - 1);
    localparam logic [LW-1:0] VS_LAST   = LW'(V_SYNC - 1);
    localparam logic [LW-1:0] VB_LAST   = LW'(V_BACK - 1);
    localparam logic [LW-1:0] VA_LAST   = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] VF_LAST   = LW'(V_FRONT - 1);

    logic [DW-1:0] div_reg;
    logic          pclk_reg;
    logic          div_tick;
    logic          fall_tick;

    cam_state_e    state_reg, state_next;
    logic [BW-1:0] byte_reg, byte_next;
    logic [LW-1:0] line_reg, line_next;
    logic          pending_reg, pending_next;
    logic          consume;
    logic          go;
    logic          line_end;

    cam_cfg_t      cfg_reg;
    logic [11:0]   pix_color;
    logic          vsync_reg, href_reg;
    logic [7:0]    data_reg;

    // Prescaler: toggle pclk every PCLK_DIV clks. All bus updates happen on the
    // clk edge that takes pclk low, so the receiver's rising edge sees stable data.
    assign div_tick  = (div_reg == DW'(PCLK_DIV - 1));
    assign fall_tick = div_tick & pclk_reg;

    always_ff @(posedge clk or negedge CAM_reset_n) begin
        if (!CAM_reset_n) begin
            div_reg  <= '0;
            pclk_reg <= 1'b0;
        end else if (div_tick) begin
            div_reg  <= '0;
            pclk_reg <= ~pclk_reg;
        end else begin
            div_reg  <= div_reg + DW'(1);
        end
    end

    // A start arriving in the same clk as the decision point counts immediately.
    assign go       = pending_reg | start;
    assign line_end = (byte_reg == BYTE_LAST);

    always_comb begin
        state_next   = state_reg;
        byte_next    = byte_reg;
        line_next    = line_reg;
        consume      = 1'b0;
        frame_done   = 1'b0;
        if (fall_tick) begin
            byte_next = line_end ? '0 : byte_reg + BW'(1);
            case (state_reg)
                ST_IDLE: begin
                    byte_next = '0;
                    line_next = '0;
                    if (go) begin
                        state_next = ST_VSYNC;
                        consume    = 1'b1;
                    end
                end
                ST_VSYNC, ST_CLOSE: begin
                    if (line_end) begin
                        if (line_reg == VS_LAST) begin
                            state_next = (state_reg == ST_VSYNC) ? ST_VBACK : ST_IDLE;
                            line_next  = '0;
                        end else begin
                            line_next  = line_reg + LW'(1);
                        end
                    end
                end
                ST_VBACK: begin
                    if (line_end) begin
                        if (line_reg == VB_LAST) begin
                            state_next = ST_ACTIVE;
                            line_next  = '0;
                        end else begin
                            line_next  = line_reg + LW'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (byte_reg == ACT_LAST) state_next = ST_HBLANK;
                end
                ST_HBLANK: begin
                    if (line_end) begin
                        if (line_reg == VA_LAST) begin
                            state_next = ST_VFRONT;
                            line_next  = '0;
                        end else begin
                            state_next = ST_ACTIVE;
                            line_next  = line_reg + LW'(1);
                        end
                    end
                end
                ST_VFRONT: begin
                    if (line_end) begin
                        if (line_reg == VF_LAST) begin
                            frame_done = 1'b1;
                            line_next  = '0;
                            if (cont || go) begin
                                state_next = ST_VSYNC;
                                consume    = 1'b1;
                            end else begin
                                state_next = ST_CLOSE;
                            end
                        end else begin
                            line_next  = line_reg + LW'(1);
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Single pending slot: further starts while one is waiting are dropped.
    always_comb begin
        pending_next = pending_reg;
        if (consume)    pending_next = 1'b0;
        else if (start) pending_next = 1'b1;
    end

    always_ff @(posedge clk or negedge CAM_reset_n) begin
        if (!CAM_reset_n) begin
            state_reg   <= ST_IDLE;
            byte_reg    <= '0;
            line_reg    <= '0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            byte_reg    <= byte_next;
            line_reg    <= line_next;
            pending_reg <= pending_next;
        end
    end

    always_ff @(posedge clk or negedge CAM_reset_n) begin
        if (!CAM_reset_n) begin
            cfg_reg <= '0;
        end else if (fall_tick && state_next == ST_VSYNC && state_reg != ST_VSYNC) begin
            cfg_reg <= '{mode: cam_mode_e'(mode), fg: fg_color, bg: bg_color,
                         box_w: box_w, box_h: box_h};
        end
    end

    // Colour of the slot about to be driven.
    cam_pattern_rgb444 #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pattern (
        .x     (12'(byte_next[BW-1:1])),
        .y     (12'(line_next)),
        .cfg   (cfg_reg),
        .color (pix_color)
    );

    always_ff @(posedge clk or negedge CAM_reset_n) begin
        if (!CAM_reset_n) begin
            vsync_reg <= 1'b0;
            href_reg  <= 1'b0;
            data_reg  <= 8'h00;
        end else if (fall_tick) begin
            vsync_reg <= (state_next == ST_VSYNC) || (state_next == ST_CLOSE);
            href_reg  <= (state_next == ST_ACTIVE);
            data_reg  <= (state_next == ST_ACTIVE) ? rgb444_byte(pix_color, byte_next[0]) : 8'h00;
        end
    end

    assign cam.CAM_pclk    = pclk_reg;
    assign cam.CAM_vsync   = vsync_reg;
    assign cam.CAM_href    = href_reg;
    assign cam.CAM_px_data = data_reg;
    assign busy            = (state_reg != ST_IDLE) | pending_reg;

endmodule

// File: tb/tb_cam_stream_gen.sv
module tb_cam_stream_gen;
    import cam_pkg::*;

    localparam int H    = 32;
    localparam int V    = 17;
    localparam int HB   = 4;
    localparam int VS   = 3;
    localparam int VB   = 2;
    localparam int VF   = 2;
    localparam int DIV  = 2;
    localparam int LINE = 2 * H + HB;

    logic        clk;
    logic        CAM_reset_n;
    logic        start;
    logic        cont;
    logic [1:0]  mode;
    logic [11:0] fg_color, bg_color, box_w, box_h;
    logic        busy, frame_done;

    cam_stream_gen_if cif();

    cam_stream_gen #(
        .H_ACTIVE (H), .V_ACTIVE (V), .H_BLANK (HB),
        .V_SYNC (VS), .V_BACK (VB), .V_FRONT (VF), .PCLK_DIV (DIV)
    ) dut (
        .clk         (clk),
        .CAM_reset_n (CAM_reset_n),
        .start       (start),
        .cont        (cont),
        .mode        (mode),
        .fg_color    (fg_color),
        .bg_color    (bg_color),
        .box_w       (box_w),
        .box_h       (box_h),
        .cam         (cif),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] fg;
        logic [11:0] bg;
        logic [11:0] bw;
        logic [11:0] bh;
        int          py;
        int          exp_lines;
        int          exp_cnt;
        int          exp_first;
        logic [7:0]  exp_b0;
        logic [7:0]  exp_b1;
    } vec_t;

    vec_t vecs [5];

    int checks   = 0;
    int failures = 0;

    // Capture-side monitor, sampling on the receiver's rising pclk edge.
    logic [11:0] pix [0:V-1][0:H-1];
    int   href_cnt = 0, bad_len = 0, junk = 0, cur_len = 0, vs_len = 0, vs_rises = 0;
    logic vs_d = 1'b0, href_d = 1'b0;
    logic [3:0] rbyte = 4'h0;

    always @(posedge cif.CAM_pclk) begin
        if (cif.CAM_vsync) begin
            if (!vs_d) begin
                vs_rises = vs_rises + 1;
                href_cnt = 0; bad_len = 0; junk = 0; vs_len = 0;
            end
            vs_len = vs_len + 1;
        end
        if (cif.CAM_href) begin
            if (cur_len % 2 == 0) begin
                rbyte = cif.CAM_px_data[3:0];
                if (cif.CAM_px_data[7:4] != 4'h0) junk = junk + 1;
            end else if (href_cnt < V && cur_len / 2 < H) begin
                pix[href_cnt][cur_len / 2] = {rbyte, cif.CAM_px_data};
            end
            cur_len = cur_len + 1;
        end else begin
            if (href_d) begin
                href_cnt = href_cnt + 1;
                if (cur_len != 2 * H) bad_len = bad_len + 1;
            end
            cur_len = 0;
            if (cif.CAM_px_data != 8'h00) junk = junk + 1;
        end
        vs_d   = cif.CAM_vsync;
        href_d = cif.CAM_href;
    end

    int   fd_cnt = 0, fd_wide = 0;
    logic fd_prev = 1'b0;
    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            if (fd_prev) fd_wide = fd_wide + 1;
        end
        fd_prev = frame_done;
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void count_fg(input logic [11:0] fg, input int y,
                                     output int cnt, output int first);
        cnt = 0; first = -1;
        for (int x = 0; x < H; x++) begin
            if (pix[y][x] == fg) begin
                if (first < 0) first = x;
                cnt = cnt + 1;
            end
        end
    endfunction

    task automatic apply_cfg(input vec_t v);
        mode = v.mode; fg_color = v.fg; bg_color = v.bg; box_w = v.bw; box_h = v.bh;
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        int i = 0;
        while (!ok && i < 8000) begin
            @(negedge clk);
            if (frame_done) ok = 1;
            i++;
        end
        check({name, "_frame_done_seen"}, int'(ok), 1);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        int i = 0;
        while (!ok && i < 2000) begin
            @(negedge clk);
            if (!busy) ok = 1;
            i++;
        end
        check({name, "_busy_cleared"}, int'(ok), 1);
    endtask

    task automatic start_with_latency(input string name);
        int lat = 0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (lat == 0 && cif.CAM_vsync) lat = n;
        end
        check({name, "_vsync_latency_in_range"}, int'(lat >= 1 && lat <= 2 * DIV + 1), 1);
    endtask

    task automatic check_frame(input vec_t v, input string name);
        int cnt, first, lines, c2, f2;
        check({name, "_href_pulses"}, href_cnt, V);
        check({name, "_bad_href_len"}, bad_len, 0);
        check({name, "_junk_bytes"}, junk, 0);
        lines = 0;
        for (int y = 0; y < V; y++) begin
            count_fg(v.fg, y, c2, f2);
            if (c2 > 0) lines++;
        end
        check({name, "_fg_lines"}, lines, v.exp_lines);
        count_fg(v.fg, v.py, cnt, first);
        check({name, "_probe_fg_cnt"}, cnt, v.exp_cnt);
        check({name, "_probe_first_x"}, first, v.exp_first);
        check({name, "_probe_px0"}, int'(pix[v.py][0]), int'({v.exp_b0[3:0], v.exp_b1}));
    endtask

    task automatic run_vec(input vec_t v, input string name);
        apply_cfg(v);
        cont = 1'b0;
        start_with_latency(name);
        wait_done(name);
        check_frame(v, name);
        wait_idle(name);
        check({name, "_close_vsync_len"}, vs_len, VS * LINE);
    endtask

    initial begin
        int changes, vs_high, c, f, viol, prev, fd0, vr0;
        logic pclk_prev;
        bit ok;

        //              mode  fg      bg      bw     bh     py  lines cnt first b0     b1
        vecs[0] = '{2'd0, 12'hF00, 12'h000, 12'd0,  12'd0,  4,  17, 32, 0,  8'h0F, 8'h00};
        vecs[1] = '{2'd1, 12'h0F0, 12'h00F, 12'd0,  12'd0,  4,  17, 16, 16, 8'h00, 8'h0F};
        vecs[2] = '{2'd2, 12'h0F0, 12'h000, 12'd8,  12'd4,  7,  4,  8,  12, 8'h00, 8'h00};
        vecs[3] = '{2'd2, 12'hABC, 12'h123, 12'd40, 12'd40, 0,  17, 32, 0,  8'h0A, 8'hBC};
        vecs[4] = '{2'd3, 12'hFFF, 12'h000, 12'd0,  12'd0,  16, 17, 32, 0,  8'h0F, 8'hFF};

        CAM_reset_n = 1'b0;
        start = 1'b0; cont = 1'b0;
        mode = 2'd0; fg_color = '0; bg_color = '0; box_w = '0; box_h = '0;
        repeat (5) @(negedge clk);
        check("reset_outputs_zero",
              int'({cif.CAM_pclk, cif.CAM_vsync, cif.CAM_href, cif.CAM_px_data, busy, frame_done}), 0);
        CAM_reset_n = 1'b1;

        changes = 0; vs_high = 0;
        @(negedge clk);
        pclk_prev = cif.CAM_pclk;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cif.CAM_pclk != pclk_prev) changes++;
            if (cif.CAM_vsync) vs_high++;
            pclk_prev = cif.CAM_pclk;
        end
        check("pclk_toggles_in_8_clk", changes, 4);
        check("idle_vsync_high", vs_high, 0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Triangle: width 2y+1, strictly growing until it saturates on line 16.
        count_fg(12'hFFF, 3, c, f);
        check("tri_y3_cnt", c, 7);
        check("tri_y3_first", f, 13);
        count_fg(12'hFFF, 15, c, f);
        check("tri_y15_cnt", c, 31);
        check("tri_y15_first", f, 1);
        viol = 0; prev = 0;
        for (int y = 0; y < V; y++) begin
            count_fg(12'hFFF, y, c, f);
            if (c <= prev) viol++;
            prev = c;
        end
        check("tri_growth_violations", viol, 0);

        // Continuous mode: three frames back-to-back, CLOSE only after the third.
        apply_cfg(vecs[0]);
        fd0 = fd_cnt; vr0 = vs_rises;
        cont = 1'b1;
        start_with_latency("cont");
        wait_done("cont1");
        check("cont_busy_between_frames", int'(busy), 1);
        wait_done("cont2");
        @(posedge clk);
        #1;
        cont = 1'b0;
        wait_done("cont3");
        check_frame(vecs[0], "cont3");
        wait_idle("cont");
        check("cont_frame_done_count", fd_cnt - fd0, 3);
        check("cont_vsync_rises", vs_rises - vr0, 4);

        // Start coinciding with frame_done and cont low: next frame follows without CLOSE.
        apply_cfg(vecs[1]);
        fd0 = fd_cnt; vr0 = vs_rises;
        start_with_latency("pend");
        wait_done("pend1");
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("pend2");
        check_frame(vecs[1], "pend2");
        wait_idle("pend");
        check("pend_frame_done_count", fd_cnt - fd0, 2);
        check("pend_vsync_rises", vs_rises - vr0, 3);

        // Reset in the middle of an active line.
        apply_cfg(vecs[0]);
        start_with_latency("rst");
        ok = 0;
        for (int i = 0; i < 8000 && !ok; i++) begin
            @(negedge clk);
            if (cif.CAM_href && href_cnt == 5 && cur_len == 20) ok = 1;
        end
        check("rst_reached_mid_line", int'(ok), 1);
        CAM_reset_n = 1'b0;
        #1;
        check("rst_href_data_zero", int'({cif.CAM_href, cif.CAM_px_data}), 0);
        check("rst_other_outputs_zero", int'({cif.CAM_pclk, cif.CAM_vsync, busy}), 0);
        repeat (3) @(negedge clk);
        CAM_reset_n = 1'b1;
        vs_high = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cif.CAM_vsync || busy) vs_high++;
        end
        check("rst_no_spontaneous_frame", vs_high, 0);
        run_vec(vecs[0], "post_rst");

        check("frame_done_wider_than_1clk", fd_wide, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
